// File: rtl/lmc1992_pkg.sv
// Shared constants, frame layout and gain table for the LMC1992 microwire responder.
package lmc1992_pkg;

  localparam int unsigned MW_BITS  = 11;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned GAIN_W   = 9;
  localparam int unsigned K_W      = 7;

  localparam logic [1:0] FRAME_ADDR = 2'b10;

  localparam logic [2:0] FN_MIX    = 3'd0;
  localparam logic [2:0] FN_BASS   = 3'd1;
  localparam logic [2:0] FN_TREBLE = 3'd2;
  localparam logic [2:0] FN_MASTER = 3'd3;
  localparam logic [2:0] FN_RIGHT  = 3'd4;
  localparam logic [2:0] FN_LEFT   = 3'd5;

  localparam logic [5:0] MASTER_MAX = 6'd40;
  localparam logic [5:0] SIDE_MAX   = 6'd20;
  localparam logic [5:0] TONE_MAX   = 6'd12;

  localparam logic [5:0] MASTER_RST = 6'd40;
  localparam logic [4:0] SIDE_RST   = 5'd20;
  localparam logic [3:0] TONE_RST   = 4'd6;
  localparam logic [1:0] MIX_RST    = 2'd1;
  localparam logic [7:0] SAMPLE_RST = 8'h80;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } frame_state_t;

  typedef struct packed {
    logic [1:0] addr;
    logic [2:0] fn;
    logic [5:0] data;
  } mw_frame_t;

  // round(256 * 10^(-k/10)) for k = 0..60
  localparam logic [8:0] GAIN_TAB [61] = '{
    9'd256, 9'd203, 9'd162, 9'd128, 9'd102, 9'd81,  9'd64,  9'd51,
    9'd41,  9'd32,  9'd26,  9'd20,  9'd16,  9'd13,  9'd10,  9'd8,
    9'd6,   9'd5,   9'd4,   9'd3,   9'd3,   9'd2,   9'd2,   9'd1,
    9'd1,   9'd1,   9'd1,   9'd1,   9'd0,   9'd0,   9'd0,   9'd0,
    9'd0,   9'd0,   9'd0,   9'd0,   9'd0,   9'd0,   9'd0,   9'd0,
    9'd0,   9'd0,   9'd0,   9'd0,   9'd0,   9'd0,   9'd0,   9'd0,
    9'd0,   9'd0,   9'd0,   9'd0,   9'd0,   9'd0,   9'd0,   9'd0,
    9'd0,   9'd0,   9'd0,   9'd0,   9'd0
  };

  function automatic logic [5:0] clamp6(input logic [5:0] d, input logic [5:0] mx);
    return (d > mx) ? mx : d;
  endfunction

  function automatic logic [8:0] gain_of(input logic [6:0] k);
    if (k > 7'd60) return 9'd0;
    return GAIN_TAB[k[5:0]];
  endfunction

endpackage

// File: rtl/lmc1992_rx_gain.sv
// Two-stage per-channel attenuator: offset removal, signed gain multiply, floor shift, offset restore.
module lmc_gain
  import lmc1992_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_strobe,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic [GAIN_W-1:0]   i_gain,
  output logic [SAMPLE_W-1:0] o_sample,
  output logic                o_valid
);

  logic [SAMPLE_W-1:0] r_s;
  logic [GAIN_W-1:0]   r_gain;
  logic                r_v1;
  logic [SAMPLE_W-1:0] r_out;
  logic                r_valid;

  logic signed [16:0] w_s_ext;
  logic signed [16:0] w_g_ext;
  logic signed [16:0] w_p;
  logic               w_unused_p;

  // Flipping the MSB turns offset-binary into two's complement and back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s    <= '0;
      r_gain <= '0;
      r_v1   <= 1'b0;
    end else begin
      r_s    <= i_sample ^ 8'h80;
      r_gain <= i_gain;
      r_v1   <= i_strobe;
    end
  end

  assign w_s_ext    = 17'(signed'(r_s));
  assign w_g_ext    = signed'({8'b0, r_gain});
  assign w_p        = w_s_ext * w_g_ext;
  // Product fits 17 bits; bits [15:8] are the low byte of the floor shift.
  assign w_unused_p = ^{w_p[16], w_p[7:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out   <= SAMPLE_RST;
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_v1;
      if (r_v1) r_out <= w_p[15:8] ^ 8'h80;
    end
  end

  assign o_sample = r_out;
  assign o_valid  = r_valid;

endmodule

// File: rtl/lmc1992_rx.sv
// LMC1992 microwire responder: frame receive/decode into control registers and sample attenuation.
module lmc1992_rx
  import lmc1992_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk32,
  input  logic       res,
  input  logic       mw_clk,
  input  logic       mw_data,
  input  logic       mw_en,
  input  logic       snd_strobe,
  input  logic [7:0] snd_left_in,
  input  logic [7:0] snd_right_in,
  output logic [7:0] snd_left_out,
  output logic [7:0] snd_right_out,
  output logic       snd_valid,
  output logic [5:0] master_vol,
  output logic [4:0] left_vol,
  output logic [4:0] right_vol,
  output logic [3:0] bass,
  output logic [3:0] treble,
  output logic [1:0] mix,
  output logic       frame_ok,
  output logic       frame_err
);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic [SYNC_STAGES-1:0] r_en_sync;
  logic                   r_clk_d;
  logic                   r_en_d;

  logic [MW_BITS-1:0] r_sr;
  logic [CNT_W-1:0]   r_cnt;
  frame_state_t       r_state;

  logic [5:0] r_master;
  logic [4:0] r_left;
  logic [4:0] r_right;
  logic [3:0] r_bass;
  logic [3:0] r_treble;
  logic [1:0] r_mix;
  logic       r_ok;
  logic       r_err;

  logic               w_clk_s, w_data_s, w_en_s;
  logic               w_clk_rise, w_en_rise, w_en_fall, w_shift;
  logic [MW_BITS-1:0] w_sr_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  mw_frame_t          w_frame;
  logic               w_frame_valid;
  frame_state_t       w_state_nxt;
  logic               w_eval;
  logic [K_W-1:0]     w_att_m, w_k_l, w_k_r;
  logic [GAIN_W-1:0]  w_gain_l, w_gain_r;
  logic               w_valid_l, w_unused_valid_r;

  // Enable syncs reset high so a frame already in progress at reset release is never entered.
  always_ff @(posedge clk32 or posedge res) begin
    if (res) begin
      r_clk_sync  <= '0;
      r_data_sync <= '0;
      r_en_sync   <= '1;
      r_clk_d     <= 1'b0;
      r_en_d      <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], mw_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], mw_data};
      r_en_sync   <= {r_en_sync[SYNC_STAGES-2:0], mw_en};
      r_clk_d     <= w_clk_s;
      r_en_d      <= w_en_s;
    end
  end

  assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s   = r_data_sync[SYNC_STAGES-1];
  assign w_en_s     = r_en_sync[SYNC_STAGES-1];
  assign w_clk_rise = w_clk_s & ~r_clk_d;
  assign w_en_rise  = w_en_s & ~r_en_d;
  assign w_en_fall  = ~w_en_s & r_en_d;
  assign w_shift    = w_clk_rise & (w_en_s | r_en_d);

  // Next shift/count values include a bit arriving in the same cycle as the enable fall.
  always_comb begin
    w_sr_nxt  = r_sr;
    w_cnt_nxt = r_cnt;
    if (w_en_rise) w_cnt_nxt = '0;
    if (w_shift) begin
      w_sr_nxt = {r_sr[MW_BITS-2:0], w_data_s};
      if (w_cnt_nxt != CNT_W'(MW_BITS)) w_cnt_nxt = w_cnt_nxt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk32 or posedge res) begin
    if (res) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else begin
      r_sr  <= w_sr_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // Frame tracker: only frames whose enable rise was seen after reset are evaluated.
  always_ff @(posedge clk32 or posedge res) begin
    if (res) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_en_rise) w_state_nxt = ST_RECV;
      ST_RECV: if (w_en_fall) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_eval = 1'b0;
    if (r_state == ST_RECV) w_eval = w_en_fall;
  end

  assign w_frame       = mw_frame_t'(w_sr_nxt);
  assign w_frame_valid = (w_cnt_nxt == CNT_W'(MW_BITS)) && (w_frame.addr == FRAME_ADDR)
                         && (w_frame.fn <= FN_LEFT);

  always_ff @(posedge clk32 or posedge res) begin
    if (res) begin
      r_master <= MASTER_RST;
      r_left   <= SIDE_RST;
      r_right  <= SIDE_RST;
      r_bass   <= TONE_RST;
      r_treble <= TONE_RST;
      r_mix    <= MIX_RST;
      r_ok     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_ok  <= w_eval & w_frame_valid;
      r_err <= w_eval & ~w_frame_valid;
      if (w_eval && w_frame_valid) begin
        case (w_frame.fn)
          FN_MIX:    r_mix    <= w_frame.data[1:0];
          FN_BASS:   r_bass   <= 4'(clamp6(w_frame.data, TONE_MAX));
          FN_TREBLE: r_treble <= 4'(clamp6(w_frame.data, TONE_MAX));
          FN_MASTER: r_master <= clamp6(w_frame.data, MASTER_MAX);
          FN_RIGHT:  r_right  <= 5'(clamp6(w_frame.data, SIDE_MAX));
          FN_LEFT:   r_left   <= 5'(clamp6(w_frame.data, SIDE_MAX));
          default:   ;
        endcase
      end
    end
  end

  // Attenuation index combines master and side steps; gains read the current registers.
  assign w_att_m  = K_W'(MASTER_MAX) - K_W'(r_master);
  assign w_k_l    = w_att_m + (K_W'(SIDE_MAX) - K_W'(r_left));
  assign w_k_r    = w_att_m + (K_W'(SIDE_MAX) - K_W'(r_right));
  assign w_gain_l = gain_of(w_k_l);
  assign w_gain_r = gain_of(w_k_r);

  lmc_gain u_gain_l (
    .clk      (clk32),
    .rst      (res),
    .i_strobe (snd_strobe),
    .i_sample (snd_left_in),
    .i_gain   (w_gain_l),
    .o_sample (snd_left_out),
    .o_valid  (w_valid_l)
  );

  lmc_gain u_gain_r (
    .clk      (clk32),
    .rst      (res),
    .i_strobe (snd_strobe),
    .i_sample (snd_right_in),
    .i_gain   (w_gain_r),
    .o_sample (snd_right_out),
    .o_valid  (w_unused_valid_r)
  );

  assign snd_valid  = w_valid_l;
  assign master_vol = r_master;
  assign left_vol   = r_left;
  assign right_vol  = r_right;
  assign bass       = r_bass;
  assign treble     = r_treble;
  assign mix        = r_mix;
  assign frame_ok   = r_ok;
  assign frame_err  = r_err;

endmodule

// File: tb/tb_lmc1992_rx.sv
// Directed bench for lmc1992_rx: microwire frames, clamping, error frames, reset abort, sample gain.
module tb_lmc1992_rx;

  logic       clk32 = 1'b0;
  logic       res;
  logic       mw_clk, mw_data, mw_en;
  logic       snd_strobe;
  logic [7:0] snd_left_in, snd_right_in;
  logic [7:0] snd_left_out, snd_right_out;
  logic       snd_valid;
  logic [5:0] master_vol;
  logic [4:0] left_vol, right_vol;
  logic [3:0] bass, treble;
  logic [1:0] mix;
  logic       frame_ok, frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_ok     = 0;
  int n_err    = 0;
  int ok0, err0;

  lmc1992_rx #(.SYNC_STAGES(2)) dut (
    .clk32         (clk32),
    .res           (res),
    .mw_clk        (mw_clk),
    .mw_data       (mw_data),
    .mw_en         (mw_en),
    .snd_strobe    (snd_strobe),
    .snd_left_in   (snd_left_in),
    .snd_right_in  (snd_right_in),
    .snd_left_out  (snd_left_out),
    .snd_right_out (snd_right_out),
    .snd_valid     (snd_valid),
    .master_vol    (master_vol),
    .left_vol      (left_vol),
    .right_vol     (right_vol),
    .bass          (bass),
    .treble        (treble),
    .mix           (mix),
    .frame_ok      (frame_ok),
    .frame_err     (frame_err)
  );

  always #5 clk32 = ~clk32;

  always @(posedge clk32) begin
    if (frame_ok)  n_ok  <= n_ok + 1;
    if (frame_err) n_err <= n_err + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk32);
  endtask

  task automatic check_regs(input string tag, input int m, input int l, input int r,
                            input int b, input int t, input int mx);
    check({tag, "_master"}, 32'(master_vol), 32'(m));
    check({tag, "_left"},   32'(left_vol),   32'(l));
    check({tag, "_right"},  32'(right_vol),  32'(r));
    check({tag, "_bass"},   32'(bass),       32'(b));
    check({tag, "_treble"}, 32'(treble),     32'(t));
    check({tag, "_mix"},    32'(mix),        32'(mx));
  endtask

  task automatic en_up();
    mw_en = 1'b1;
    wait_cyc(4);
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mw_data = bits[i];
      wait_cyc(4);
      mw_clk = 1'b1;
      wait_cyc(4);
      mw_clk = 1'b0;
    end
  endtask

  task automatic en_down();
    wait_cyc(4);
    mw_en = 1'b0;
    wait_cyc(8);
  endtask

  task automatic send_frame(input logic [15:0] bits, input int n);
    en_up();
    send_bits(bits, n);
    en_down();
  endtask

  // One strobe; outputs are due two clocks later as a single-cycle valid pulse.
  task automatic sample(input string tag, input logic [7:0] l_in, input logic [7:0] r_in,
                        input logic [7:0] l_exp, input logic [7:0] r_exp);
    @(negedge clk32);
    snd_left_in  = l_in;
    snd_right_in = r_in;
    snd_strobe   = 1'b1;
    @(negedge clk32);
    snd_strobe   = 1'b0;
    @(posedge clk32);
    #1;
    check({tag, "_valid"}, 32'(snd_valid), 32'd1);
    check({tag, "_lout"},  32'(snd_left_out),  32'(l_exp));
    check({tag, "_rout"},  32'(snd_right_out), 32'(r_exp));
    @(posedge clk32);
    #1;
    check({tag, "_valid_end"}, 32'(snd_valid), 32'd0);
  endtask

  initial begin
    res = 1'b1;
    mw_clk = 1'b0; mw_data = 1'b0; mw_en = 1'b0;
    snd_strobe = 1'b0; snd_left_in = 8'h80; snd_right_in = 8'h80;
    wait_cyc(3);
    res = 1'b0;
    wait_cyc(4);

    check_regs("rst", 40, 20, 20, 6, 6, 1);
    check("rst_lout", 32'(snd_left_out), 32'h80);
    check("rst_rout", 32'(snd_right_out), 32'h80);
    check("rst_valid", 32'(snd_valid), 32'd0);
    check("rst_pulses", 32'(n_ok + n_err), 32'd0);

    sample("pass", 8'hC0, 8'h00, 8'hC0, 8'h00);

    ok0 = n_ok; err0 = n_err;
    send_frame(16'b10011010100, 11);
    check("master_ok", 32'(n_ok - ok0), 32'd1);
    check("master_err", 32'(n_err - err0), 32'd0);
    check("master_val", 32'(master_vol), 32'd20);
    sample("att20", 8'hFF, 8'h00, 8'h81, 8'h7E);

    ok0 = n_ok;
    send_frame(16'b10001111111, 11);
    check("bass_ok", 32'(n_ok - ok0), 32'd1);
    check("bass_clamp", 32'(bass), 32'd12);

    ok0 = n_ok; err0 = n_err;
    send_frame(16'b100110101, 9);
    send_frame(16'b01011010100, 11);
    send_frame(16'b10110000011, 11);
    check("bad_err", 32'(n_err - err0), 32'd3);
    check("bad_ok", 32'(n_ok - ok0), 32'd0);
    check_regs("bad", 20, 20, 20, 12, 6, 1);

    ok0 = n_ok; err0 = n_err;
    send_frame(16'b1110101000101, 13);
    check("long_ok", 32'(n_ok - ok0), 32'd1);
    check("long_err", 32'(n_err - err0), 32'd0);
    check("long_left", 32'(left_vol), 32'd5);
    sample("att35", 8'hFF, 8'h00, 8'h80, 8'h7E);

    ok0 = n_ok; err0 = n_err;
    en_up();
    send_bits(16'b100110, 6);
    res = 1'b1;
    wait_cyc(3);
    res = 1'b0;
    send_bits(16'b00000, 5);
    en_down();
    check("abort_ok", 32'(n_ok - ok0), 32'd0);
    check("abort_err", 32'(n_err - err0), 32'd0);
    check_regs("abort", 40, 20, 20, 6, 6, 1);
    sample("post_rst", 8'h12, 8'hEE, 8'h12, 8'hEE);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lmc1992_rx.md
# lmc1992_rx

Microwire responder that models the STE's LMC1992 volume/tone controller at the far end of the shifter's microwire port. It deserializes 11-bit command frames, decodes and clamps them into volume, tone and mix registers, and applies the combined master and side attenuation to the 8-bit DMA sound samples. The block sits between the shifter's audio outputs and the audio mixer.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth on mw_clk, mw_data and mw_en.

Ports:
- clk32  in  1  system clock.
- res  in  1  reset. One clock; reset is asynchronous and active-high.
- mw_clk  in  1  microwire serial clock; data is sampled on its rising edge.
- mw_data  in  1  microwire serial data, MSB first.
- mw_en  in  1  frame envelope, active-high; its falling edge ends the frame.
- snd_strobe  in  1  one-cycle pulse; a new sample pair is valid.
- snd_left_in, snd_right_in  in  8  offset-binary samples (0x80 = silence).
- snd_left_out, snd_right_out  out  8  attenuated offset-binary samples.
- snd_valid  out  1  one-cycle pulse; outputs updated.
- master_vol  out  6  0..40 (2 dB steps, 40 = 0 dB).
- left_vol, right_vol  out  5  0..20 (2 dB steps, 20 = 0 dB).
- bass, treble  out  4  0..12 (6 = flat).
- mix  out  2  mix select.
- frame_ok, frame_err  out  1  one-cycle pulses at end of frame.

## Operation
- The inputs pass through SYNC_STAGES flops; edges are detected on the synchronized signals.
- Rising edge of mw_clk while mw_en is high: shift mw_data into an 11-bit shift register (LSB in) and increment the bit count, which saturates at 11. Edges while mw_en is low are ignored.
- Rising edge of mw_en: clear the bit count.
- Falling edge of mw_en: evaluate the frame. It is valid if the bit count is 11, bits[10:9] = 2'b10, and the function code in bits[8:6] is 0..5. Over-long frames use the last 11 bits.
- Function codes: 000 mix = data[1:0]; 001 bass; 010 treble; 011 master; 100 right; 101 left.
- Data is bits[5:0], clamped to the field maximum (40, 20 or 12) and then truncated to the field width.
- A valid frame updates exactly one register and pulses frame_ok. Any other frame, including one with fewer than 11 bits, pulses frame_err and leaves all registers unchanged.
- Attenuation:
  - Per-channel attenuation index k = (40 − master_vol) + (20 − side_vol), range 0..60.
  - gain = GAIN_TAB[k], a 9-bit value equal to round(256·10^(−k/10)). For example, k = 0 gives 256 and k = 20 gives 3.
- Sample path:
  - s = in − 128, 8-bit signed.
  - p = s × gain, 17-bit signed.
  - out = (p >>> 8) + 128, using an arithmetic (floor) shift.
  - At 0 dB the sample passes through exactly.
- Reset values:
  - master_vol 40, left_vol and right_vol 20, bass and treble 6, mix 1.
  - Shift register and bit count cleared.
  - snd_left_out and snd_right_out 0x80.
  - snd_valid, frame_ok and frame_err 0.

## Timing
- Register update latency: frame_ok/frame_err and the register write occur SYNC_STAGES+1 cycles after mw_en falls at the pin.
- A mw_clk rise and a mw_en fall that are detected in the same cycle: the bit is shifted in first, then the frame is evaluated including that bit.
- Sample pipeline:
  - Stage 1 registers s and gain, reading the gain as it is before any same-cycle register write.
  - Stage 2 registers the outputs and snd_valid.
  - Latency is 2 cycles, with a throughput of one strobe per cycle.
- Minimum mw_clk high and low times: SYNC_STAGES+1 cycles each.
- Reset asserted mid-frame aborts the frame with no pulse. Reset asserted mid-pipeline drops in-flight samples (no snd_valid is issued for them).

## Structure
- lmc1992_pkg holds:
  - function-code constants;
  - field maxima (40, 20, 12);
  - reset values;
  - the 61-entry GAIN_TAB constant (entries 28..60 = 0).
- Sub-module lmc_gain holds the two-stage, per-channel subtract/multiply/shift/offset pipeline. It is instantiated twice, once for left and once for right.

## Test plan
- After reset, drive snd_in 0xC0/0x00 -> outputs are 0xC0/0x00 two cycles later, with one snd_valid pulse.
- Send frame 10_011_010100 (master = 20) -> master_vol = 20 and frame_ok. Then drive left input 0xFF -> left output 0x81 (gain 3).
- Send frame 10_001_111111 (bass = 63) -> bass = 12 (clamped) and frame_ok.
- Send a 9-bit frame, then a frame with address 01, then function 110 -> three frame_err pulses and all registers unchanged.
- Send a 13-bit frame 11 + 10_101_000101 -> left_vol = 5 and frame_ok.
- Assert res after 6 bits of a frame, then release it and complete the frame -> no pulse and all registers at their reset values.
